// File: rtl/cpupem_pkg.sv
// Shared definitions for the CPUPEM sequencer: default widths, opcode values,
// FSM state encoding and the decode-flag bundle shared with the ALU side.
package cpupem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_JC    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_WRITE  = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  typedef struct packed {
    logic needs_read;
    logic is_store;
    logic is_alu;
    logic is_jump;
    logic is_halt;
  } dec_flags_t;

  // Only the arithmetic ops propagate the ALU carry; logic ops clear it.
  function automatic logic op_sets_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cpupem_decode.sv
// Combinational opcode classifier used by the sequencer's DECODE dispatch.
module cpupem_decode
  import cpupem_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_flags_t flags
);

  // Map each opcode to its dispatch class; reserved opcodes behave as NOP.
  always_comb begin
    flags = '0;
    case (opcode)
      OP_LOAD:                             flags.needs_read = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        flags.needs_read = 1'b1;
        flags.is_alu     = 1'b1;
      end
      OP_STORE:                            flags.is_store = 1'b1;
      OP_JMP, OP_JZ, OP_JC:                flags.is_jump  = 1'b1;
      OP_HALT:                             flags.is_halt  = 1'b1;
      default:                             flags = '0;
    endcase
  end

endmodule

// File: rtl/cpupem_sequencer.sv
// Multi-cycle accumulator CPU sequencer driving an external RAM and ALU,
// with a program loader usable while idle or halted.
module cpupem_sequencer
  import cpupem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              halted,
  output logic [2:0]        dbg_state
);

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] ir_r;
  logic              zero_r;
  logic              carry_r;

  dec_flags_t        dec_s;
  logic              jump_taken_s;
  logic [ADDR_W-1:0] operand_s;
  logic [3:0]        exec_op_s;

  cpupem_decode u_decode (
    .opcode (mem_rdata[7:4]),
    .flags  (dec_s)
  );

  assign operand_s = ADDR_W'(ir_r[3:0]);
  assign exec_op_s = ir_r[7:4];

  assign alu_a  = acc_r;
  assign alu_b  = mem_rdata;
  assign alu_op = exec_op_s;

  assign acc       = acc_r;
  assign pc        = pc_r;
  assign ir        = ir_r;
  assign dbg_state = state_r;
  assign busy      = (state_r >= ST_FETCH) && (state_r <= ST_WRITE);
  assign halted    = (state_r == ST_HALT);

  // Conditional-branch resolution on the instruction word arriving in DECODE.
  always_comb begin
    jump_taken_s = 1'b0;
    case (mem_rdata[7:4])
      OP_JMP:  jump_taken_s = dec_s.is_jump;
      OP_JZ:   jump_taken_s = dec_s.is_jump && zero_r;
      OP_JC:   jump_taken_s = dec_s.is_jump && carry_r;
      default: jump_taken_s = 1'b0;
    endcase
  end

  // RAM port steering; reset suppresses any write so an aborted STORE never lands.
  always_comb begin
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_we    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (ld_we && !reset) begin
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          mem_we    = 1'b1;
        end else begin
          mem_we    = 1'b0;
        end
      end
      ST_FETCH: mem_addr = pc_r;
      ST_READ:  mem_addr = operand_s;
      ST_WRITE: begin
        mem_addr  = operand_s;
        mem_wdata = acc_r;
        mem_we    = !reset;
      end
      default:  mem_we = 1'b0;
    endcase
  end

  // Architectural state and FSM sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      pc_r    <= {ADDR_W{1'b0}};
      acc_r   <= {DATA_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            pc_r    <= {ADDR_W{1'b0}};
            acc_r   <= {DATA_W{1'b0}};
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
            state_r <= ST_FETCH;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FETCH: state_r <= ST_DECODE;
        ST_DECODE: begin
          ir_r <= mem_rdata;
          if (jump_taken_s) pc_r <= ADDR_W'(mem_rdata[3:0]);
          else              pc_r <= pc_r + ADDR_W'(1'b1);
          if (dec_s.needs_read || dec_s.is_alu) state_r <= ST_READ;
          else if (dec_s.is_store)              state_r <= ST_WRITE;
          else if (dec_s.is_halt)               state_r <= ST_HALT;
          else                                  state_r <= ST_FETCH;
        end
        ST_READ: state_r <= ST_EXEC;
        ST_EXEC: begin
          if (exec_op_s == OP_LOAD) begin
            acc_r  <= mem_rdata;
            zero_r <= (mem_rdata == {DATA_W{1'b0}});
          end else begin
            acc_r   <= alu_result;
            zero_r  <= (alu_result == {DATA_W{1'b0}});
            carry_r <= op_sets_carry(exec_op_s) ? alu_carry : 1'b0;
          end
          state_r <= ST_FETCH;
        end
        ST_WRITE: state_r <= ST_FETCH;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
